// File: rtl/uart_receiver_if.sv
// Bundle between the BTINT serial receiver and its neighbours: the serial
// line coming in and the captured parallel word going out.
// master: drives the serial line and consumes the word.
// slave : the receiver itself.
interface uart_receiver_if #(
  parameter int NUM_DIGITS = 3
);
  logic                      line;
  logic [8*NUM_DIGITS-1:0]   btint_a;
  logic [8*NUM_DIGITS-1:0]   btint_b;
  logic                      valid;
  logic                      frame_error;

  modport master (
    output line,
    input  btint_a,
    input  btint_b,
    input  valid,
    input  frame_error
  );

  modport slave (
    input  line,
    output btint_a,
    output btint_b,
    output valid,
    output frame_error
  );
endinterface

// File: rtl/uart_receiver.sv
// BTINT digit-link receiver. Each digit travels as two frames (low nibble
// then high nibble) of start + 8 interleaved a/b bits + stop bits; digits
// arrive most significant first and a complete word is presented with a
// one-cycle valid pulse.
// Optional feature macro: UART_RECEIVER_FRAME_ERROR_EN
//   defined   -> low stop bit sets a sticky frame_error, drops the partial
//                word and waits for one full high bit-time before re-arming.
//   undefined -> stop-bit values are ignored and frame_error is tied low.
// All state changes happen at the last cycle of a bit-time, so the next
// start bit is seen by IDLE in the very first cycle it is on the line.
module uart_receiver #(
  parameter int CLKS_PER_BIT  = 1,
  parameter int NUM_STOP_BITS = 2,
  parameter int NUM_DIGITS    = 3
) (
  input  logic          uart_receiver_clock,
  input  logic          uart_receiver_reset,
  uart_receiver_if.slave bus
);

  localparam int W     = 8 * NUM_DIGITS;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W = ($clog2(NUM_STOP_BITS) > 3) ? $clog2(NUM_STOP_BITS) : 3;

  localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST_DATA = BIT_W'(7);
  localparam logic [BIT_W-1:0] BIT_LAST_STOP = BIT_W'(NUM_STOP_BITS - 1);
  localparam logic [DIG_W-1:0] DIG_LAST      = DIG_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;        // cycle within the current bit-time
  logic [BIT_W-1:0] bit_reg, bit_next;        // data or stop bit index
  logic             frame_reg, frame_next;    // 0: low nibble, 1: high nibble
  logic [DIG_W-1:0] digit_reg, digit_next;    // digit within the word, MSD = 0
  logic [7:0]       shadow_a_reg, shadow_a_next;
  logic [7:0]       shadow_b_reg, shadow_b_next;
  logic [W-1:0]     out_a_reg, out_b_reg;
  logic             valid_reg;
  logic [W-1:0]     word_a_full, word_b_full;
  logic             complete_frame;
  logic             slot_load;
  logic             word_done;
  logic             at_sample;
  logic             at_end;

`ifdef UART_RECEIVER_FRAME_ERROR_EN
  logic             stop_bad_reg, stop_bad_next;
  logic             ferr_reg, ferr_next;
  logic             stop_low;
`endif

  assign at_sample = (cnt_reg == CNT_HALF);
  assign at_end    = (cnt_reg == CNT_LAST);

  // Next-state, bit sampling and frame/digit bookkeeping.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    frame_next     = frame_reg;
    digit_next     = digit_reg;
    shadow_a_next  = shadow_a_reg;
    shadow_b_next  = shadow_b_reg;
    complete_frame = 1'b0;
    slot_load      = 1'b0;
    word_done      = 1'b0;
`ifdef UART_RECEIVER_FRAME_ERROR_EN
    stop_bad_next  = stop_bad_reg;
    ferr_next      = ferr_reg;
    stop_low       = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
`ifdef UART_RECEIVER_FRAME_ERROR_EN
        stop_bad_next = 1'b0;
`endif
        // This cycle is already the first cycle of the start bit; with a
        // single-cycle bit it is also the start-bit sample point.
        if (!bus.line) begin
          if (CLKS_PER_BIT == 1) begin
            state_next = DATA;
          end else begin
            state_next = START;
            cnt_next   = CNT_W'(1);
          end
        end
      end

      START: begin
        if (at_sample && bus.line) begin
          // Line went back high before mid-bit: treat as a glitch.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (at_end) begin
          state_next = DATA;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (at_sample) begin
          if (!bit_reg[0]) begin
            shadow_a_next = {bus.line, shadow_a_reg[7:1]};
          end else begin
            shadow_b_next = {bus.line, shadow_b_reg[7:1]};
          end
        end
        if (at_end) begin
          cnt_next = '0;
          if (bit_reg == BIT_LAST_DATA) begin
            state_next = STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP: begin
`ifdef UART_RECEIVER_FRAME_ERROR_EN
        stop_low = at_sample && !bus.line;
        if (stop_low) begin
          stop_bad_next = 1'b1;
        end
`endif
        if (at_end) begin
          cnt_next = '0;
          if (bit_reg != BIT_LAST_STOP) begin
            bit_next = bit_reg + 1'b1;
          end else begin
            state_next = IDLE;
            bit_next   = '0;
`ifdef UART_RECEIVER_FRAME_ERROR_EN
            if (stop_bad_reg || stop_low) begin
              ferr_next  = 1'b1;
              frame_next = 1'b0;
              digit_next = '0;
              state_next = RECOVER;
            end else begin
              complete_frame = 1'b1;
            end
`else
            complete_frame = 1'b1;
`endif
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RECOVER: begin
        // Re-arm only after a full bit-time of continuous high line.
        if (!bus.line) begin
          cnt_next = '0;
        end else if (at_end) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (complete_frame) begin
      if (!frame_reg) begin
        frame_next = 1'b1;
      end else begin
        frame_next = 1'b0;
        slot_load  = 1'b1;
        if (digit_reg == DIG_LAST) begin
          digit_next = '0;
          word_done  = 1'b1;
        end else begin
          digit_next = digit_reg + 1'b1;
        end
      end
    end
  end

  // FSM state, counters and shift registers.
  always_ff @(posedge uart_receiver_clock) begin
    if (uart_receiver_reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      frame_reg    <= 1'b0;
      digit_reg    <= '0;
      shadow_a_reg <= '0;
      shadow_b_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      frame_reg    <= frame_next;
      digit_reg    <= digit_next;
      shadow_a_reg <= shadow_a_next;
      shadow_b_reg <= shadow_b_next;
    end
  end

  // Completed digits park in per-slot holding registers. The last digit is
  // never parked: it goes from the shadow registers straight to the output.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      if (gi == 0) begin : g_last
        assign word_a_full[7:0] = shadow_a_reg;
        assign word_b_full[7:0] = shadow_b_reg;
      end else begin : g_held
        logic [7:0] held_a_reg;
        logic [7:0] held_b_reg;

        // Capture this slot when its digit finishes its second frame.
        always_ff @(posedge uart_receiver_clock) begin
          if (uart_receiver_reset) begin
            held_a_reg <= '0;
            held_b_reg <= '0;
          end else if (slot_load && (digit_reg == DIG_W'(NUM_DIGITS - 1 - gi))) begin
            held_a_reg <= shadow_a_reg;
            held_b_reg <= shadow_b_reg;
          end
        end

        assign word_a_full[8*gi +: 8] = held_a_reg;
        assign word_b_full[8*gi +: 8] = held_b_reg;
      end
    end
  endgenerate

  // Output word and valid pulse change only when a whole word completes.
  always_ff @(posedge uart_receiver_clock) begin
    if (uart_receiver_reset) begin
      out_a_reg <= '0;
      out_b_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= word_done;
      if (word_done) begin
        out_a_reg <= word_a_full;
        out_b_reg <= word_b_full;
      end
    end
  end

`ifdef UART_RECEIVER_FRAME_ERROR_EN
  // Sticky framing-error flag and per-frame bad-stop-bit tracker.
  always_ff @(posedge uart_receiver_clock) begin
    if (uart_receiver_reset) begin
      ferr_reg     <= 1'b0;
      stop_bad_reg <= 1'b0;
    end else begin
      ferr_reg     <= ferr_next;
      stop_bad_reg <= stop_bad_next;
    end
  end

  assign bus.frame_error = ferr_reg;
`else
  assign bus.frame_error = 1'b0;
`endif

  assign bus.btint_a = out_a_reg;
  assign bus.btint_b = out_b_reg;
  assign bus.valid   = valid_reg;

endmodule
